// File: rtl/ultrasonic_note_ranger.sv
// ultrasonic_note_ranger
//   Drives an HC-SR04-style ranger (trig out, echo in), measures the echo
//   width, converts it to whole centimetres and maps the distance onto a
//   10-bit one-hot note word (bit0 = nearest band, 0 = no note).
//   One measurement is started every PERIOD_CYCLES while en=1.
//   Optional build macro: STABLE_NOTE_EN -- when defined, the note word only
//   updates when two consecutive measurements fall in the same band.
module ultrasonic_note_ranger #(
   parameter int TRIG_CYCLES    = 1000,
   parameter int PERIOD_CYCLES  = 6000000,
   parameter int TIMEOUT_CYCLES = 3000000,
   parameter int CYC_PER_CM     = 5800,
   parameter int MIN_CM         = 5,
   parameter int BAND_CM        = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       echo,
   output logic       trig,
   output logic [9:0] note,
   output logic [8:0] dist_cm,
   output logic       valid,
   output logic       timeout
);

   localparam int TW = $clog2(TRIG_CYCLES + 1);
   localparam int PW = $clog2(PERIOD_CYCLES + 1);
   localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SW = $clog2(CYC_PER_CM + 1);

   localparam logic [TW-1:0] TRIG_LAST   = TW'(TRIG_CYCLES - 1);
   localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
   localparam logic [OW-1:0] TMO_LAST    = OW'(TIMEOUT_CYCLES - 1);
   localparam logic [SW-1:0] SUB_LAST    = SW'(CYC_PER_CM - 1);
   localparam logic [8:0]    CM_MAX      = 9'd511;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_TRIG      = 3'd1,
      S_WAIT_RISE = 3'd2,
      S_MEASURE   = 3'd3,
      S_CONVERT   = 3'd4,
      S_HOLDOFF   = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic          trig_q, trig_d;
   logic [TW-1:0] trig_cnt_q, trig_cnt_d;
   logic [PW-1:0] period_q, period_d;
   logic [OW-1:0] tmo_q, tmo_d;
   logic [SW-1:0] sub_q, sub_d;
   logic [8:0]    cm_q, cm_d;
   logic [9:0]    note_q, note_d;
   logic [8:0]    dist_q, dist_d;
   logic          valid_q, valid_d;
   logic          timeout_q, timeout_d;
`ifdef STABLE_NOTE_EN
   logic [9:0]    hist_note_q, hist_note_d;
   logic          hist_vld_q, hist_vld_d;
`endif

   logic          echo_s1_q, echo_s2_q, echo_s3_q;
   logic          echo_sync_s, echo_rise_s;
   logic          conv_go_s, conv_tmo_s;
   logic [9:0]    new_note_s;
   logic [8:0]    new_dist_s;
   logic [SW+8:0] step_s;

   // One echo-high cycle: advance the sub-cycle counter, carry into whole cm (saturating).
   function automatic logic [SW+8:0] cm_step(input logic [SW-1:0] sub, input logic [8:0] cm);
      logic [SW+8:0] r;
      if (sub == SUB_LAST) begin
         if (cm == CM_MAX) begin
            r = {cm, {SW{1'b0}}};
         end else begin
            r = {cm + 9'd1, {SW{1'b0}}};
         end
      end else begin
         r = {cm, sub + SW'(1)};
      end
      return r;
   endfunction

   // Comparator chain: one window per band, at most one window can match.
   function automatic logic [9:0] map_note(input logic [8:0] cm);
      logic [9:0] n;
      int         cm_i;
      int         lo;
      cm_i = int'({23'd0, cm});
      n    = 10'd0;
      for (int i = 0; i < 10; i++) begin
         lo = MIN_CM + i * BAND_CM;
         if ((cm_i >= lo) && (cm_i < lo + BAND_CM)) begin
            n[i] = 1'b1;
         end else begin
            n[i] = 1'b0;
         end
      end
      return n;
   endfunction

   assign echo_sync_s = echo_s2_q;
   assign echo_rise_s = echo_s2_q & ~echo_s3_q;
   assign step_s      = cm_step(sub_q, cm_q);
   assign new_dist_s  = conv_tmo_s ? CM_MAX : cm_q;
   assign new_note_s  = conv_tmo_s ? 10'd0 : map_note(cm_q);

   // Two-flop synchroniser for the asynchronous echo plus one extra stage for edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         echo_s1_q <= 1'b0;
         echo_s2_q <= 1'b0;
         echo_s3_q <= 1'b0;
      end else begin
         echo_s1_q <= echo;
         echo_s2_q <= echo_s1_q;
         echo_s3_q <= echo_s2_q;
      end
   end

   // Next-state logic: sequencing, counters and the single-cycle conversion update.
   always_comb begin
      state_d    = state_q;
      trig_d     = trig_q;
      trig_cnt_d = trig_cnt_q;
      tmo_d      = tmo_q;
      sub_d      = sub_q;
      cm_d       = cm_q;
      note_d     = note_q;
      dist_d     = dist_q;
      valid_d    = 1'b0;
      timeout_d  = timeout_q;
      conv_go_s  = 1'b0;
      conv_tmo_s = 1'b0;
`ifdef STABLE_NOTE_EN
      hist_note_d = hist_note_q;
      hist_vld_d  = hist_vld_q;
`endif
      // the period counter runs from trig rise and parks at its last value
      if ((state_q != S_IDLE) && (period_q < PERIOD_LAST)) begin
         period_d = period_q + PW'(1);
      end else begin
         period_d = period_q;
      end

      if (!en) begin
         // leaving ranging mode: abort everything, keep the last reported note/distance
         state_d    = S_IDLE;
         trig_d     = 1'b0;
         trig_cnt_d = '0;
         period_d   = '0;
         tmo_d      = '0;
         sub_d      = '0;
         cm_d       = 9'd0;
`ifdef STABLE_NOTE_EN
         hist_vld_d = 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d    = S_TRIG;
               trig_d     = 1'b1;
               trig_cnt_d = '0;
               period_d   = '0;
            end
            S_TRIG: begin
               if (trig_cnt_q == TRIG_LAST) begin
                  state_d = S_WAIT_RISE;
                  trig_d  = 1'b0;
                  tmo_d   = '0;
                  sub_d   = '0;
                  cm_d    = 9'd0;
               end else begin
                  trig_cnt_d = trig_cnt_q + TW'(1);
               end
            end
            S_WAIT_RISE: begin
               if (tmo_q == TMO_LAST) begin
                  conv_tmo_s = 1'b1;
               end else if (echo_rise_s) begin
                  // the edge cycle is the first high cycle, so it is counted
                  state_d = S_MEASURE;
                  tmo_d   = tmo_q + OW'(1);
                  {cm_d, sub_d} = cm_step({SW{1'b0}}, 9'd0);
               end else begin
                  tmo_d = tmo_q + OW'(1);
               end
            end
            S_MEASURE: begin
               if (tmo_q == TMO_LAST) begin
                  conv_tmo_s = 1'b1;
               end else if (echo_sync_s) begin
                  tmo_d         = tmo_q + OW'(1);
                  {cm_d, sub_d} = step_s;
               end else begin
                  conv_go_s = 1'b1;
               end
            end
            S_CONVERT: begin
               state_d = S_HOLDOFF;
            end
            S_HOLDOFF: begin
               if (period_q >= PERIOD_LAST) begin
                  state_d    = S_TRIG;
                  trig_d     = 1'b1;
                  trig_cnt_d = '0;
                  period_d   = '0;
               end else begin
                  state_d = S_HOLDOFF;
               end
            end
            default: begin
               state_d = S_IDLE;
               trig_d  = 1'b0;
            end
         endcase

         if (conv_go_s || conv_tmo_s) begin
            state_d   = S_CONVERT;
            valid_d   = 1'b1;
            dist_d    = new_dist_s;
            timeout_d = conv_tmo_s;
`ifdef STABLE_NOTE_EN
            if (hist_vld_q && (hist_note_q == new_note_s)) begin
               note_d = new_note_s;
            end else begin
               note_d = note_q;
            end
            hist_note_d = new_note_s;
            hist_vld_d  = 1'b1;
`else
            note_d = new_note_s;
`endif
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         trig_q      <= 1'b0;
         trig_cnt_q  <= '0;
         period_q    <= '0;
         tmo_q       <= '0;
         sub_q       <= '0;
         cm_q        <= 9'd0;
         note_q      <= 10'd0;
         dist_q      <= 9'd0;
         valid_q     <= 1'b0;
         timeout_q   <= 1'b0;
`ifdef STABLE_NOTE_EN
         hist_note_q <= 10'd0;
         hist_vld_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         trig_q      <= trig_d;
         trig_cnt_q  <= trig_cnt_d;
         period_q    <= period_d;
         tmo_q       <= tmo_d;
         sub_q       <= sub_d;
         cm_q        <= cm_d;
         note_q      <= note_d;
         dist_q      <= dist_d;
         valid_q     <= valid_d;
         timeout_q   <= timeout_d;
`ifdef STABLE_NOTE_EN
         hist_note_q <= hist_note_d;
         hist_vld_q  <= hist_vld_d;
`endif
      end
   end

   assign trig    = trig_q;
   assign note    = note_q;
   assign dist_cm = dist_q;
   assign valid   = valid_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_ultrasonic_note_ranger.sv
// Self-checking bench for ultrasonic_note_ranger with small timing parameters.
module tb_ultrasonic_note_ranger;

   localparam int TRIG_C   = 5;
   localparam int PERIOD_C = 400;
   localparam int TMO_C    = 200;
   localparam int CPC      = 10;
   localparam int MINCM    = 5;
   localparam int BANDCM   = 3;

   logic       clk = 1'b0;
   logic       rst_n, en, echo;
   logic       trig, valid, timeout;
   logic [9:0] note;
   logic [8:0] dist_cm;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [9:0] m_note;
   logic [8:0] m_dist;
   logic       m_tmo;
   int         m_prev_band;   // -1 = no history, 10 = no-note band

   ultrasonic_note_ranger #(
      .TRIG_CYCLES(TRIG_C), .PERIOD_CYCLES(PERIOD_C), .TIMEOUT_CYCLES(TMO_C),
      .CYC_PER_CM(CPC), .MIN_CM(MINCM), .BAND_CM(BANDCM)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .echo(echo), .trig(trig),
      .note(note), .dist_cm(dist_cm), .valid(valid), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Reference: what one finished measurement should report.
   task automatic model_measure(input int len, input bit tmo);
      int cm, band;
      logic [9:0] nn;
      cm = tmo ? 511 : ((len / CPC) > 511 ? 511 : len / CPC);
      if (tmo || cm < MINCM || cm >= MINCM + 10 * BANDCM) band = 10;
      else band = (cm - MINCM) / BANDCM;
      nn = 10'd0;
      if (band != 10) nn[band] = 1'b1;
      m_dist = 9'(cm);
      m_tmo  = tmo;
`ifdef STABLE_NOTE_EN
      if (m_prev_band == band) m_note = nn;
      m_prev_band = band;
`else
      m_note = nn;
      m_prev_band = band;
`endif
   endtask

   // One measurement: wait for trig fall, drive echo, check the reported result.
   task automatic run_measurement(input string tag, input int delay, input int len, input bit stuck);
      bit seen, got, exp_tmo, prev;
      int vk;
      logic [9:0] s_note;
      logic [8:0] s_dist;
      logic       s_tmo;
      exp_tmo = stuck || (len == 0) || (delay + len > 190);
      if (stuck) echo = 1'b1;
      seen = 1'b0;
      prev = trig;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (prev && !trig) begin seen = 1'b1; break; end
         prev = trig;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL %s trig_fall: no falling trig within 1000 cycles", tag);
         return;
      end
      got = 1'b0; vk = 0;
      s_note = '0; s_dist = '0; s_tmo = 1'b0;
      for (int k = 1; k <= 600; k++) begin
         @(negedge clk);
         if (!stuck && len > 0) begin
            if (k == delay) echo = 1'b1;
            if (k == delay + len) echo = 1'b0;
         end
         if (got && k == vk + 1) begin
            total++;
            if (valid !== 1'b0) begin bad++; $display("FAIL %s valid_width: got %b need 0 one cycle after strobe", tag, valid); end
            if (stuck) echo = 1'b0;
         end
         if (valid && !got) begin
            got = 1'b1; vk = k;
            s_note = note; s_dist = dist_cm; s_tmo = timeout;
         end
         if (got && k > vk && (stuck || len == 0 || k >= delay + len)) break;
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL %s valid: no strobe within 600 cycles of trig fall", tag);
         echo = 1'b0;
         return;
      end
      model_measure(len, exp_tmo);
      total++;
      if (s_dist !== m_dist) begin bad++; $display("FAIL %s dist_cm: got %0d need %0d", tag, s_dist, m_dist); end
      total++;
      if (s_note !== m_note) begin bad++; $display("FAIL %s note: got %b need %b", tag, s_note, m_note); end
      total++;
      if (s_tmo !== m_tmo) begin bad++; $display("FAIL %s timeout: got %b need %b", tag, s_tmo, m_tmo); end
      if (len == 0 || stuck) begin
         total++;
         if (vk != TMO_C) begin bad++; $display("FAIL %s timeout_latency: got %0d need %0d", tag, vk, TMO_C); end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; echo = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({trig, note, dist_cm, valid, timeout} !== 22'd0) begin
         bad++;
         $display("FAIL reset_outputs: got trig=%b note=%b dist=%0d valid=%b tmo=%b need all 0", trig, note, dist_cm, valid, timeout);
      end
      rst_n = 1'b1;
      m_note = 10'd0; m_dist = 9'd0; m_tmo = 1'b0; m_prev_band = -1;
      repeat (2) @(negedge clk);
      total++;
      if (trig !== 1'b0) begin bad++; $display("FAIL idle_trig: got %b need 0 with en=0", trig); end
   endtask

   task automatic test_trig_timing();
      bit exp_trig;
      en = 1'b1;
      for (int k = 1; k <= 401; k++) begin
         @(negedge clk);
         exp_trig = (k <= TRIG_C) || (k == PERIOD_C + 1);
         total++;
         if (trig !== exp_trig) begin bad++; $display("FAIL trig_k%0d: got %b need %b", k, trig, exp_trig); end
         total++;
         if (valid !== (k == TRIG_C + 1 + TMO_C)) begin bad++; $display("FAIL valid_k%0d: got %b", k, valid); end
         if (k == TRIG_C + 1 + TMO_C) begin
            model_measure(0, 1'b1);
            total++;
            if (dist_cm !== m_dist || note !== m_note || timeout !== 1'b1) begin
               bad++;
               $display("FAIL first_timeout: got dist=%0d note=%b tmo=%b need %0d %b 1", dist_cm, note, timeout, m_dist, m_note);
            end
         end
      end
   endtask

   task automatic test_spec_values();
      run_measurement("echo100", 5, 100, 1'b0);
      run_measurement("echo40", 7, 40, 1'b0);
      run_measurement("echo360", 5, 360, 1'b0);
      run_measurement("echo100b", 3, 100, 1'b0);
   endtask

   task automatic test_timeout();
      run_measurement("no_echo", 0, 0, 1'b0);
      run_measurement("stuck_high", 0, 0, 1'b1);
   endtask

   task automatic test_random();
      int d, l;
      for (int i = 0; i < 10; i++) begin
         d = int'($urandom_range(1, 20));
         if ($urandom_range(0, 3) == 0) l = int'($urandom_range(230, 300));
         else l = int'($urandom_range(1, 160));
         run_measurement($sformatf("rand%0d", i), d, l, 1'b0);
      end
   endtask

   task automatic test_stable_sequence();
      run_measurement("seq100", 4, 100, 1'b0);
      run_measurement("seq130a", 4, 130, 1'b0);
      run_measurement("seq130b", 4, 130, 1'b0);
   endtask

   task automatic test_reset_mid();
      bit seen, prev, saw_valid;
      seen = 1'b0; prev = trig;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (prev && !trig) begin seen = 1'b1; break; end
         prev = trig;
      end
      total++;
      if (!seen) begin bad++; $display("FAIL rstmid_trig_fall: none within 1000 cycles"); return; end
      repeat (3) @(negedge clk);
      echo = 1'b1;
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if ({trig, note, dist_cm, valid, timeout} !== 22'd0) begin
         bad++;
         $display("FAIL rstmid_outputs: got trig=%b note=%b dist=%0d valid=%b tmo=%b need all 0", trig, note, dist_cm, valid, timeout);
      end
      echo = 1'b0;
      saw_valid = 1'b0;
      repeat (3) begin @(negedge clk); if (valid) saw_valid = 1'b1; end
      total++;
      if (saw_valid) begin bad++; $display("FAIL rstmid_no_valid: got strobe during reset need none"); end
      m_note = 10'd0; m_dist = 9'd0; m_tmo = 1'b0; m_prev_band = -1;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (trig !== 1'b1) begin bad++; $display("FAIL rstmid_restart_trig: got %b need 1", trig); end
      run_measurement("after_rst", 6, 70, 1'b0);
   endtask

   task automatic test_en_drop();
      bit seen, prev, saw_valid, saw_trig;
      seen = 1'b0; prev = trig;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (prev && !trig) begin seen = 1'b1; break; end
         prev = trig;
      end
      total++;
      if (!seen) begin bad++; $display("FAIL endrop_trig_fall: none within 1000 cycles"); return; end
      repeat (3) @(negedge clk);
      echo = 1'b1;
      repeat (40) @(negedge clk);
      en = 1'b0;
      echo = 1'b0;
      saw_valid = 1'b0; saw_trig = 1'b0;
      repeat (500) begin
         @(negedge clk);
         if (valid) saw_valid = 1'b1;
         if (trig) saw_trig = 1'b1;
      end
      total++;
      if (saw_valid) begin bad++; $display("FAIL endrop_valid: got strobe need none"); end
      total++;
      if (saw_trig) begin bad++; $display("FAIL endrop_trig: got trig high need low"); end
      total++;
      if (note !== m_note || dist_cm !== m_dist) begin
         bad++;
         $display("FAIL endrop_hold: got note=%b dist=%0d need %b %0d", note, dist_cm, m_note, m_dist);
      end
      m_prev_band = -1;
      en = 1'b1;
      run_measurement("after_en", 5, 120, 1'b0);
      run_measurement("after_en2", 5, 121, 1'b0);
   endtask

   initial begin
      test_reset();
      test_trig_timing();
      test_spec_values();
      test_timeout();
      test_stable_sequence();
      test_random();
      test_reset_mid();
      test_en_drop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
